// File: rtl/imem_ctrl_pkg.sv
// Purpose: shared types and sizing for the instruction-memory load/fetch controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_ctrl_pkg;

  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 32;

  // ST_CLEAR is only entered in builds that zero-fill memory before loading.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_load_arbiter.sv
// Purpose: shares one instruction-memory port between a boot loader (LOAD) and CPU fetch (RUN).
// Latency: loader write in the accept cycle; fetch_instr/fetch_valid one cycle after fetch_req.
// Backpressure: ld_ready high only in LOAD; cpu_stall holds the CPU outside RUN.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start_load                     pulse in RUN to reload the program
//   ld_valid/ld_data/ld_last       loader word stream, accepted when ld_ready
//   fetch_req/fetch_addr           CPU fetch, answered by fetch_valid/fetch_instr
//   mem_a/mem_d/mem_we/mem_spo     async-read, sync-write memory in the parent
//   cpu_stall, boot_done           CPU hold / program-loaded status
//   load_count, ld_overflow        words written; sticky "memory filled without ld_last"
// Build option: define IMEM_CLEAR_ON_LOAD_EN to zero-fill all of memory before every load.
module imem_load_arbiter
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo,
  output logic              cpu_stall,
  output logic              boot_done,
  output logic [ADDR_W:0]   load_count,
  output logic              ld_overflow
);

`ifdef IMEM_CLEAR_ON_LOAD_EN
  localparam imem_state_t ENTRY_ST = ST_CLEAR;
`else
  localparam imem_state_t ENTRY_ST = ST_LOAD;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  imem_state_t state;
  logic        ld_acc;

`ifdef IMEM_CLEAR_ON_LOAD_EN
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  logic [ADDR_W-1:0] clr_addr;
`endif

  assign ld_acc    = ld_ready & ld_valid;
  // Reset is sampled synchronously, so the handshake outputs are also masked
  // during the reset cycle to keep the memory and loader quiet.
  assign cpu_stall = rst | (state != ST_RUN);

  always_comb begin
    ld_ready = 1'b0;
    mem_we   = 1'b0;
    mem_a    = fetch_addr;
    mem_d    = '0;
    if (!rst) begin
      case (state)
        ST_LOAD: begin
          ld_ready = 1'b1;
          mem_we   = ld_valid;
          mem_a    = load_count[ADDR_W-1:0];
          mem_d    = ld_data;
        end
`ifdef IMEM_CLEAR_ON_LOAD_EN
        ST_CLEAR: begin
          mem_we = 1'b1;
          mem_a  = clr_addr;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY_ST;
      load_count  <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      boot_done   <= 1'b0;
      ld_overflow <= 1'b0;
`ifdef IMEM_CLEAR_ON_LOAD_EN
      clr_addr    <= '0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          fetch_valid <= 1'b0;
          if (ld_acc) begin
            load_count <= load_count + CNT_ONE;
            // Leaving on the top address keeps load_count from wrapping past DEPTH.
            if (ld_last || (load_count[ADDR_W-1:0] == LAST_ADDR)) begin
              state       <= ST_RUN;
              boot_done   <= 1'b1;
              ld_overflow <= ~ld_last;
            end
          end
        end
        ST_RUN: begin
          if (start_load) begin
            // A fetch in the same cycle is dropped: reload takes priority.
            state       <= ENTRY_ST;
            load_count  <= '0;
            boot_done   <= 1'b0;
            ld_overflow <= 1'b0;
            fetch_valid <= 1'b0;
          end else begin
            fetch_valid <= fetch_req;
            if (fetch_req) begin
              fetch_instr <= mem_spo;
            end
          end
        end
`ifdef IMEM_CLEAR_ON_LOAD_EN
        ST_CLEAR: begin
          fetch_valid <= 1'b0;
          clr_addr    <= clr_addr + ADDR_ONE;
          if (clr_addr == LAST_ADDR) begin
            state <= ST_LOAD;
          end
        end
`endif
        default: begin
          state       <= ENTRY_ST;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_load_arbiter.md
IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width (depth 2**ADDR_W = 1024).
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_load  in  1  pulse; re-enters load mode from RUN.
REQ-006 ld_valid  in  1  loader word present.
REQ-007 ld_data  in  DATA_W  loader instruction word.
REQ-008 ld_last  in  1  qualifies final word of program.
REQ-009 ld_ready  out  1  arbiter accepts loader word this cycle.
REQ-010 fetch_req  in  1  CPU fetch request.
REQ-011 fetch_addr  in  ADDR_W  CPU fetch word address.
REQ-012 fetch_valid  out  1  fetch_instr valid.
REQ-013 fetch_instr  out  DATA_W  registered fetched instruction.
REQ-014 mem_a  out  ADDR_W, mem_d  out  DATA_W, mem_we  out  1, mem_spo  in  DATA_W  port to async-read/sync-write distributed memory.
REQ-015 cpu_stall  out  1  CPU must hold PC; boot_done  out  1  program loaded; load_count  out  ADDR_W+1  words written; ld_overflow  out  1  sticky, load ended by full memory without ld_last.

Function
REQ-016 FSM states: LOAD, RUN (plus CLEAR, see REQ-030); one state active at a time.
REQ-017 LOAD: ld_ready=1; on ld_valid&ld_ready drive mem_we=1, mem_a=load_count[ADDR_W-1:0], mem_d=ld_data; load_count increments next edge.
REQ-018 LOAD exit: accepted word with ld_last=1, or accepted word at address 1023 -> RUN next cycle; latter without ld_last sets ld_overflow.
REQ-019 mem_we SHALL be 0 outside LOAD-accept cycles (and CLEAR writes); never asserted in RUN.
REQ-020 RUN: ld_ready=0; mem_a=fetch_addr combinationally; on fetch_req, fetch_instr<=mem_spo and fetch_valid<=1 next cycle (latency 1); fetch_valid<=0 when no request.
REQ-021 fetch_req outside RUN ignored: fetch_valid stays 0, fetch_instr holds.
REQ-022 start_load in RUN: next state LOAD (or CLEAR), load_count<=0, boot_done<=0, ld_overflow<=0; a simultaneous fetch_req is dropped (start_load wins).
REQ-023 start_load in LOAD/CLEAR ignored.
REQ-024 cpu_stall=1 in every state except RUN; boot_done=1 only in RUN.
REQ-025 load_count holds its final value in RUN; max value 1024.

Reset
REQ-026 rst at an edge forces state LOAD (CLEAR when macro defined), load_count=0, fetch_valid=0, fetch_instr=0, boot_done=0, ld_overflow=0, irrespective of current state.
REQ-027 During the rst cycle ld_ready=0, mem_we=0, cpu_stall=1.
REQ-028 rst mid-load discards progress; next load restarts at address 0.

Configuration
REQ-029 Macro IMEM_CLEAR_ON_LOAD_EN selects zero-fill before load.
REQ-030 Defined: CLEAR state precedes every LOAD (after reset and start_load); writes 0 to addresses 0..1023, one per cycle, mem_we=1, ld_ready=0, then LOAD; 1024 cycles.
REQ-031 Undefined: CLEAR state absent; reset/start_load go directly to LOAD; stale words beyond program remain.

Structure
REQ-032 Package imem_ctrl_pkg holds state typedef, IMEM_DEPTH=1024, IMEM_ADDR_W=10, IMEM_DATA_W=32.
REQ-033 No sub-module; memory instance lives in parent, connected via mem_* ports.

Verification
REQ-034 Reset, load 4 words 0x11,0x22,0x33,0x44 (last on 4th) -> mem writes at 0..3, load_count=4, boot_done=1 one cycle after 4th accept.
REQ-035 RUN, fetch_req with fetch_addr=2 -> fetch_valid=1 and fetch_instr=0x33 next cycle; cpu_stall=0.
REQ-036 Load 1024 words, ld_last never set -> RUN after word 1023, ld_overflow=1, load_count=1024.
REQ-037 start_load and fetch_req same cycle in RUN -> fetch_valid stays 0, state LOAD, cpu_stall=1, load_count=0.
REQ-038 rst asserted after 2 of 5 words -> next load writes from address 0; mem_we=0 in reset cycle.
REQ-039 With IMEM_CLEAR_ON_LOAD_EN: after reset, ld_ready=0 for 1024 cycles, memory all zero, then ld_ready=1.
